// File: rtl/blocking_buffer_mst_rd.sv
// blocking_buffer_mst_rd
// Output-side blocking buffer. It collects one result row per cycle from the
// systolic array. When the matrix is complete it waits for the DMA grant. It
// then serves the whole matrix as AXI4 R-channel beats. The buffer is only
// ever in one of these three phases.
//
// Ports:
//   clk_i, rst_n_i      clock, asynchronous active-low reset
//   in_valid_i/data_i   result row from the array; in_ready_o high while collecting
//   full_o              matrix complete, waiting for grant_i
//   grant_i             DMA arbiter grant; ar_burst_i/ar_len_i qualify the request
//   s_axi_r*            AXI4 R channel toward the DMA
//   draining_o          buffer is serving the R burst
module blocking_buffer_mst_rd #(
  parameter int AXI_DW_g = 64,
  parameter int depth_g  = 16
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                in_valid_i,
  input  logic [AXI_DW_g-1:0] in_data_i,
  output logic                in_ready_o,
  output logic                full_o,
  input  logic                grant_i,
  input  logic [1:0]          ar_burst_i,
  input  logic [7:0]          ar_len_i,
  output logic                s_axi_rvalid_o,
  input  logic                s_axi_rready_i,
  output logic [AXI_DW_g-1:0] s_axi_rdata_o,
  output logic [1:0]          s_axi_rresp_o,
  output logic                s_axi_rlast_o,
  output logic                draining_o
);

  localparam int AW = (depth_g > 1) ? $clog2(depth_g) : 1;
  localparam logic [AW-1:0] LAST_IDX = AW'(depth_g - 1);

  localparam logic [1:0] ST_COLLECT = 2'd0;
  localparam logic [1:0] ST_WAIT    = 2'd1;
  localparam logic [1:0] ST_DRAIN   = 2'd2;

  logic [1:0]          state_q,    state_d;
  logic [AW-1:0]       wr_ptr_q,   wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q,   rd_ptr_d;
  logic                resp_err_q, resp_err_d;
  logic                wr_en;
  logic [AXI_DW_g-1:0] mem_q [depth_g];

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    resp_err_d = resp_err_q;
    wr_en      = 1'b0;
    case (state_q)
      ST_COLLECT: begin
        // grant_i is deliberately ignored here; the arbiter only grants on full_o.
        if (in_valid_i) begin
          wr_en = 1'b1;
          if (wr_ptr_q == LAST_IDX) begin
            wr_ptr_d = '0;
            state_d  = ST_WAIT;
          end else begin
            wr_ptr_d = wr_ptr_q + AW'(1);
          end
        end
      end
      ST_WAIT: begin
        if (grant_i) begin
          // The burst is always depth_g beats. A non-INCR burst or a wrong length
          // is only reported as SLVERR on every beat.
          resp_err_d = (ar_burst_i != 2'b01) || (ar_len_i != 8'(depth_g - 1));
          rd_ptr_d   = '0;
          state_d    = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (s_axi_rready_i) begin
          if (rd_ptr_q == LAST_IDX) begin
            rd_ptr_d = '0;
            state_d  = ST_COLLECT;
          end else begin
            rd_ptr_d = rd_ptr_q + AW'(1);
          end
        end
      end
      default: state_d = ST_COLLECT;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_COLLECT;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      resp_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      resp_err_q <= resp_err_d;
    end
  end

  // Row storage has no reset. Its contents are only meaningful after a full fill.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= in_data_i;
    end
  end

  // Memory is never written during DRAIN. A stalled beat therefore stays stable.
  assign in_ready_o     = (state_q == ST_COLLECT);
  assign full_o         = (state_q == ST_WAIT);
  assign draining_o     = (state_q == ST_DRAIN);
  assign s_axi_rvalid_o = draining_o;
  assign s_axi_rdata_o  = mem_q[rd_ptr_q];
  assign s_axi_rresp_o  = (draining_o && resp_err_q) ? 2'b10 : 2'b00;
  assign s_axi_rlast_o  = draining_o && (rd_ptr_q == LAST_IDX);

endmodule

// File: tb/tb_blocking_buffer_mst_rd.sv
// tb_blocking_buffer_mst_rd
// Self-checking bench for blocking_buffer_mst_rd (depth 16, 64-bit rows).
// Inputs are driven and outputs sampled on the falling clock edge.
// Expected R beats are queued when the grant is issued.
// Each beat is compared against the queue head until it is accepted.
module tb_blocking_buffer_mst_rd;

  localparam int DW    = 64;
  localparam int DEPTH = 16;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [1:0]    r;
    logic          l;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          full;
  logic          grant;
  logic [1:0]    ar_burst;
  logic [7:0]    ar_len;
  logic          rvalid;
  logic          rready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rlast;
  logic          draining;

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [DW-1:0] model_mem [DEPTH];
  beat_t         exp_q [$];

  always #5 clk = ~clk;

  blocking_buffer_mst_rd #(.AXI_DW_g(DW), .depth_g(DEPTH)) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .in_valid_i     (in_valid),
    .in_data_i      (in_data),
    .in_ready_o     (in_ready),
    .full_o         (full),
    .grant_i        (grant),
    .ar_burst_i     (ar_burst),
    .ar_len_i       (ar_len),
    .s_axi_rvalid_o (rvalid),
    .s_axi_rready_i (rready),
    .s_axi_rdata_o  (rdata),
    .s_axi_rresp_o  (rresp),
    .s_axi_rlast_o  (rlast),
    .draining_o     (draining)
  );

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; grant = 1'b0;
    ar_burst = 2'b01; ar_len = 8'd15; rready = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({in_ready, full, rvalid, rlast, rresp, draining} !== 7'b1000000) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy=%b full=%b rv=%b rl=%b rr=%b dr=%b, want 1 0 0 0 00 0",
               in_ready, full, rvalid, rlast, rresp, draining);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || full !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got rdy=%b full=%b, want 1 0", in_ready, full);
    end
  endtask

  // Push n rows base+start.. into slots start..; full_o is checked after the last slot.
  task automatic test_fill(input logic [DW-1:0] base, input int start, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b1 || full !== 1'b0) begin
        n_fail++;
        $display("FAIL fill_ready row %0d: got rdy=%b full=%b, want 1 0", start + i, in_ready, full);
      end
      in_valid = 1'b1;
      in_data  = base + DW'(start + i);
      model_mem[start + i] = base + DW'(start + i);
    end
    @(negedge clk);
    in_valid = 1'b0;
    if (start + n == DEPTH) begin
      n_checks++;
      if (full !== 1'b1 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL fill_full: got full=%b rdy=%b, want 1 0", full, in_ready);
      end
    end
  endtask

  // Grant and drain. abort_after > 0 stops after that many handshakes and leaves DRAIN active.
  task automatic test_drain(input logic [1:0] burst, input logic [7:0] len,
                            input bit toggle, input int abort_after);
    logic [1:0] er;
    int k, hs, cyc;
    beat_t b;
    er = (burst != 2'b01 || len != 8'd15) ? 2'b10 : 2'b00;
    n_checks++;
    if (full !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_pre_full: got %b, want 1", full);
    end
    grant = 1'b1; ar_burst = burst; ar_len = len;
    for (int i = 0; i < DEPTH; i++) begin
      b.d = model_mem[i]; b.r = er; b.l = (i == DEPTH - 1);
      exp_q.push_back(b);
    end
    @(negedge clk);
    grant = 1'b0;
    n_checks++;
    if (rvalid !== 1'b1 || draining !== 1'b1) begin
      n_fail++;
      $display("FAIL first_beat_latency: got rv=%b dr=%b, want 1 1", rvalid, draining);
    end
    k = 0; hs = 0; cyc = 0;
    while (exp_q.size() > 0) begin
      if (cyc >= 100) begin
        n_checks++; n_fail++;
        $display("FAIL drain_timeout: got %0d beats left, want 0", exp_q.size());
        exp_q.delete();
        break;
      end
      n_checks++;
      if (rvalid !== 1'b1 || rdata !== exp_q[0].d || rresp !== exp_q[0].r || rlast !== exp_q[0].l) begin
        n_fail++;
        $display("FAIL beat %0d: got rv=%b d=%h r=%b l=%b, want 1 d=%h r=%b l=%b",
                 hs, rvalid, rdata, rresp, rlast, exp_q[0].d, exp_q[0].r, exp_q[0].l);
      end
      rready = toggle ? (k % 3 == 0) : 1'b1;
      k++;
      if (rready) begin
        void'(exp_q.pop_front());
        hs++;
      end
      @(negedge clk);
      cyc++;
      if (abort_after > 0 && hs == abort_after) break;
    end
    rready = 1'b0;
    if (abort_after == 0) begin
      n_checks++;
      if (rvalid !== 1'b0 || in_ready !== 1'b1 || draining !== 1'b0) begin
        n_fail++;
        $display("FAIL drain_done: got rv=%b rdy=%b dr=%b, want 0 1 0", rvalid, in_ready, draining);
      end
    end
  endtask

  task automatic test_grant_ignored_and_drop();
    test_fill(64'h200, 0, 5);
    grant = 1'b1; ar_burst = 2'b01; ar_len = 8'd15;
    @(negedge clk);
    grant = 1'b0;
    n_checks++;
    if (full !== 1'b0 || in_ready !== 1'b1 || rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL grant_in_collect: got full=%b rdy=%b rv=%b, want 0 1 0", full, in_ready, rvalid);
    end
    test_fill(64'h200, 5, DEPTH - 5);
    // A row presented in WAIT_GRANT must be dropped.
    in_valid = 1'b1; in_data = 64'hDEAD_BEEF_0000_0000;
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if (full !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL push_in_wait: got full=%b rdy=%b, want 1 0", full, in_ready);
    end
    test_drain(2'b01, 8'd15, 1'b0, 0);
  endtask

  task automatic test_reset_mid_drain();
    test_fill(64'h300, 0, DEPTH);
    test_drain(2'b01, 8'd15, 1'b0, 6);
    n_checks++;
    if (rvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_abort_rvalid: got %b, want 1", rvalid);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (rvalid !== 1'b0 || in_ready !== 1'b1 || draining !== 1'b0 || full !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset_abort: got rv=%b rdy=%b dr=%b full=%b, want 0 1 0 0",
               rvalid, in_ready, draining, full);
    end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    test_fill(64'h400, 0, DEPTH);
    test_drain(2'b01, 8'd15, 1'b0, 0);
  endtask

  initial begin
    test_reset();
    test_fill(64'h100, 0, DEPTH);
    test_drain(2'b01, 8'd15, 1'b0, 0);
    test_fill(64'h100, 0, DEPTH);          // back-to-back refill right after the drain
    test_drain(2'b01, 8'd15, 1'b1, 0);     // rready 1,0,0,1,...
    test_fill(64'h500, 0, DEPTH);
    test_drain(2'b00, 8'd15, 1'b0, 0);     // non-INCR burst
    test_fill(64'h600, 0, DEPTH);
    test_drain(2'b01, 8'd7, 1'b1, 0);      // short length
    test_grant_ignored_and_drop();
    test_reset_mid_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
